nibble_serial_adder: RTL



---
 rtl/nibble_serial_adder_pkg.sv | 28 ++
 rtl/rc_adder.sv | 29 ++
 rtl/nibble_serial_adder.sv | 115 +++++++++++
 3 files changed

// File: rtl/nibble_serial_adder_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : nibble_serial_adder_pkg                                   |
// | Brief  : Shared types and constants for the nibble-serial adder.   |
// | Rev    : 1.0                                                       |
// +--------------------------------------------------------------------+
package nibble_serial_adder_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of the nibble index; never below 1 so a single-nibble build still has a counter.
    function automatic int cnt_width(input int nib);
        int w;
        w = 1;
        while ((1 << w) < nib) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rc_adder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : rc_adder                                                  |
// | Brief  : 4-bit ripple-carry adder shared across nibble slices.     |
// | Rev    : 1.0                                                       |
// +--------------------------------------------------------------------+
module rc_adder
    import nibble_serial_adder_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] sum,
    output logic                cout
);

    logic [NIBBLE_W:0] w_c;

    assign w_c[0] = cin;

    for (genvar i = 0; i < NIBBLE_W; i++) begin : g_bit
        assign sum[i]   = a[i] ^ b[i] ^ w_c[i];
        assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
    end

    assign cout = w_c[NIBBLE_W];

endmodule
`default_nettype wire

// File: rtl/nibble_serial_adder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : nibble_serial_adder                                       |
// | Brief  : WIDTH-bit add/subtract sequenced LSB-first through one    |
// |          shared 4-bit ripple adder with valid/ready handshakes.    |
// | Rev    : 1.0                                                       |
// +--------------------------------------------------------------------+
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int WIDTH = 16
)
(
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int c_nib = WIDTH / NIBBLE_W;
    localparam int c_kw  = cnt_width(c_nib);
    localparam int c_msb = WIDTH - 1;
    localparam logic [c_kw-1:0] c_k_last = c_kw'(c_nib - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_sum;
    logic               r_carry;
    logic [c_kw-1:0]    r_k;

    logic [NIBBLE_W-1:0] w_a_nib;
    logic [NIBBLE_W-1:0] w_b_nib;
    logic [NIBBLE_W-1:0] w_sum_nib;
    logic                w_cout_nib;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (in_valid)         w_state_nxt = RUN;
            RUN:  if (r_k == c_k_last)  w_state_nxt = DONE;
            DONE: if (out_ready)        w_state_nxt = IDLE;
            default:                    w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_a_nib = r_a[r_k*NIBBLE_W +: NIBBLE_W];
        w_b_nib = r_b[r_k*NIBBLE_W +: NIBBLE_W];
    end

    rc_adder u_rc_adder (
        .a    (w_a_nib),
        .b    (w_b_nib),
        .cin  (r_carry),
        .sum  (w_sum_nib),
        .cout (w_cout_nib)
    );

    // Subtraction is folded into the operand latch: B inverted and carry seeded with 1.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_k     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= sub ? ~b : b;
                        r_carry <= sub ? 1'b1 : cin;
                        r_k     <= '0;
                    end
                end
                RUN: begin
                    r_sum[r_k*NIBBLE_W +: NIBBLE_W] <= w_sum_nib;
                    r_carry                          <= w_cout_nib;
                    r_k                              <= r_k + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign busy      = (r_state == RUN);
    assign out_valid = (r_state == DONE);
    assign sum       = r_sum;
    assign cout      = r_carry;
    assign ovf       = (r_a[c_msb] == r_b[c_msb]) && (r_sum[c_msb] != r_a[c_msb]);

endmodule
`default_nettype wire
